booth_seq_ctrl: RTL and testbench
=================================

Name: booth_seq_ctrl

Overview:
- Sequential radix-2 Booth multiplier controller. It applies one Booth step per clock to a single shared step datapath, instead of unrolling N stages combinationally.
- Accepts signed operand pairs over a valid/ready input channel and returns the 2N-bit signed product over a valid/ready output channel.
- Sits between operand producers (ALU/MAC sequencer) and result consumers wherever area matters more than latency.

Parameters:
- N, 8, operand width in bits (two's complement); N >= 2.
- CW, $clog2(N+1), width of the step counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  controller can accept operands.
- in_m  input  N  multiplicand M, signed.
- in_q  input  N  multiplier Q, signed.
- out_valid  output  1  product valid.
- out_ready  input  1  consumer accepts product.
- out_p  output  2N  signed product M*Q.
- busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async assert, sync release): state=IDLE; A, Q register, q_-1, M register and counter all 0.
  - Resulting outputs: in_ready=1, out_valid=0, out_p=0, busy=0.
- FSM states and transitions:
  - IDLE: in_ready=1. On in_valid&in_ready, latch M=in_m and Q=in_q; clear A and q_-1; count=N; go to CALC.
  - CALC: one Booth step per cycle, decoding {Q[0],q_-1}:
    - 01: A=A+M.
    - 10: A=A-M.
    - 00/11: no change.
    - Then arithmetic right shift of {A,Q,q_-1} by 1, with the sign of A replicated.
    - count decrements each step. After the step that brings count to 0, go to DONE.
  - DONE: out_valid=1 and out_p={A[N-1:0],Q} held stable. On out_ready go to IDLE.
- Width rule: A is held internally as N+1 bits (sign-extended M) so that M = -2^(N-1) never overflows on subtract. out_p is the low 2N bits of {A,Q}.
- Latency: accept at cycle t, N CALC cycles (t+1..t+N), out_valid from cycle t+N+1. Minimum 1 operation per N+2 cycles.
- in_ready=0 in CALC and DONE. Operands presented then are ignored, and no input state changes.
- out_valid stays high with out_p constant until out_ready. out_ready while out_valid=0 has no effect.
- out_p holds its last value in IDLE and CALC, but out_p is defined only while out_valid=1.
- Simultaneous out_ready and new in_valid in DONE: the result is consumed and the new operand is not accepted. It is taken the next cycle in IDLE.
- Reset mid-CALC or mid-DONE: the operation is aborted and no out_valid is produced. After release, the block is in IDLE.
- Counter wrap: count never wraps. CALC exits exactly at count==0.

Optional Feature:
- Macro: BOOTH_ZERO_BYPASS_EN.
- Defined: in IDLE, if the accepted in_m==0 or in_q==0, go straight to DONE with A=0 and Q=0. out_valid appears at t+1 with out_p=0.
- Undefined: zero operands take the full N-step path (out_p=0 at t+N+1).
- All other behaviour is identical in both builds.

Test Plan:
- Basic, N=8: M=3, Q=-4, out_ready=1 -> out_valid at t+9, out_p=16'hFFF4. Then in_ready=1 at t+10.
- Extreme operands: M=-128, Q=-128 -> out_p=16'h4000. M=127, Q=-128 -> 16'hC080. M=-128, Q=127 -> 16'hC080.
- Backpressure: M=5, Q=7 with out_ready=0 for 6 cycles after out_valid -> out_valid and out_p=16'h0023 stay stable. A second in_valid during the stall is not accepted (in_ready=0).
- Simultaneous event: in DONE, drive out_ready=1 and in_valid=1 (M=2, Q=2) -> first result consumed, new pair accepted one cycle later, out_p=16'h0004 at acceptance+9.
- Reset mid-op: assert rst_n=0 at CALC step 4 -> out_valid=0, in_ready=1 immediately. After release, M=-1, Q=-1 -> out_p=16'h0001.
- Zero operand: M=0, Q=-77 -> out_p=16'h0000. Latency 1 cycle with BOOTH_ZERO_BYPASS_EN, 9 cycles without.

Source files
------------

// File: rtl/booth_seq_ctrl_if.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl_if
// Operand/result handshake bundle for the sequential Booth multiplier.
//   in_valid/in_ready : operand channel (producer -> multiplier)
//   in_m, in_q        : signed multiplicand / multiplier, N bits each
//   out_valid/out_ready : product channel (multiplier -> consumer)
//   out_p             : signed 2N-bit product
// Modports:
//   master : producer/consumer side (drives operands and out_ready)
//   slave  : multiplier side
// -----------------------------------------------------------------------------
interface booth_seq_ctrl_if #(
    parameter int N = 8
);
    logic           in_valid;
    logic           in_ready;
    logic [N-1:0]   in_m;
    logic [N-1:0]   in_q;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_p;

    modport master (
        output in_valid, in_m, in_q, out_ready,
        input  in_ready, out_valid, out_p
    );

    modport slave (
        input  in_valid, in_m, in_q, out_ready,
        output in_ready, out_valid, out_p
    );
endinterface

// File: rtl/booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// booth_seq_ctrl
// Sequential radix-2 Booth multiplier: one Booth step per clock on a single
// shared add/subtract + shift datapath. Accepts an operand pair over a
// valid/ready channel and returns the 2N-bit signed product over a second
// valid/ready channel.
//
// Ports:
//   clk    : rising-edge clock
//   rst_n  : asynchronous active-low reset
//   bus    : booth_seq_ctrl_if.slave (in_valid/in_ready/in_m/in_q,
//            out_valid/out_ready/out_p)
//   busy   : high whenever the controller is not idle
//
// Build option:
//   BOOTH_ZERO_BYPASS_EN : when defined, an accepted pair with a zero operand
//                          skips the Booth steps and reports 0 one cycle later.
// -----------------------------------------------------------------------------
module booth_seq_ctrl #(
    parameter int N  = 8,
    parameter int CW = $clog2(N + 1)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    booth_seq_ctrl_if.slave         bus,
    output logic                    busy
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r, state_s;
    // Accumulator is one bit wider than the operands so that subtracting
    // M = -2^(N-1) cannot overflow.
    logic [N:0]       a_r, a_s;
    logic [N:0]       m_r, m_s;
    logic [N-1:0]     q_r, q_s;
    logic             qm1_r, qm1_s;
    logic [CW-1:0]    cnt_r, cnt_s;
    logic [2*N-1:0]   out_p_r, out_p_s;
    logic             in_ready_r, in_ready_s;
    logic             out_valid_r, out_valid_s;
    logic             busy_r, busy_s;
    logic [N:0]       sum_s;

    assign bus.in_ready  = in_ready_r;
    assign bus.out_valid = out_valid_r;
    assign bus.out_p     = out_p_r;
    assign busy          = busy_r;

    // Next-state, Booth step datapath and next values of the registered outputs.
    always_comb begin
        state_s = state_r;
        a_s     = a_r;
        m_s     = m_r;
        q_s     = q_r;
        qm1_s   = qm1_r;
        cnt_s   = cnt_r;
        out_p_s = out_p_r;
        sum_s   = a_r;

        case (state_r)
            ST_IDLE: begin
                if (bus.in_valid && in_ready_r) begin
                    m_s     = {bus.in_m[N-1], bus.in_m};
                    q_s     = bus.in_q;
                    a_s     = {(N+1){1'b0}};
                    qm1_s   = 1'b0;
                    cnt_s   = CW'(N);
                    state_s = ST_CALC;
`ifdef BOOTH_ZERO_BYPASS_EN
                    if ((bus.in_m == {N{1'b0}}) || (bus.in_q == {N{1'b0}})) begin
                        q_s     = {N{1'b0}};
                        cnt_s   = {CW{1'b0}};
                        out_p_s = {(2*N){1'b0}};
                        state_s = ST_DONE;
                    end else begin
                        state_s = ST_CALC;
                    end
`endif
                end else begin
                    state_s = ST_IDLE;
                end
            end

            ST_CALC: begin
                case ({q_r[0], qm1_r})
                    2'b01:   sum_s = a_r + m_r;
                    2'b10:   sum_s = a_r - m_r;
                    default: sum_s = a_r;
                endcase
                // Arithmetic right shift of {A,Q,q_-1} with A's sign replicated.
                a_s   = {sum_s[N], sum_s[N:1]};
                q_s   = {sum_s[0], q_r[N-1:1]};
                qm1_s = q_r[0];
                cnt_s = cnt_r - CW'(1);
                if (cnt_r == CW'(1)) begin
                    // Capture the product once so it stays constant through
                    // the following IDLE/CALC phases.
                    out_p_s = {a_s[N-1:0], q_s};
                    state_s = ST_DONE;
                end else begin
                    state_s = ST_CALC;
                end
            end

            ST_DONE: begin
                if (bus.out_ready) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DONE;
                end
            end

            default: begin
                state_s = ST_IDLE;
            end
        endcase

        in_ready_s  = (state_s == ST_IDLE);
        out_valid_s = (state_s == ST_DONE);
        busy_s      = (state_s != ST_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            a_r         <= {(N+1){1'b0}};
            m_r         <= {(N+1){1'b0}};
            q_r         <= {N{1'b0}};
            qm1_r       <= 1'b0;
            cnt_r       <= {CW{1'b0}};
            out_p_r     <= {(2*N){1'b0}};
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
        end else begin
            state_r     <= state_s;
            a_r         <= a_s;
            m_r         <= m_s;
            q_r         <= q_s;
            qm1_r       <= qm1_s;
            cnt_r       <= cnt_s;
            out_p_r     <= out_p_s;
            in_ready_r  <= in_ready_s;
            out_valid_r <= out_valid_s;
            busy_r      <= busy_s;
        end
    end

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_booth_seq_ctrl
// Directed bench for booth_seq_ctrl (N = 8) with an expected-result queue.
// -----------------------------------------------------------------------------
module tb_booth_seq_ctrl;

    localparam int N = 8;

`ifdef BOOTH_ZERO_BYPASS_EN
    localparam int ZERO_LAT = 1;
`else
    localparam int ZERO_LAT = N + 1;
`endif

    logic clk;
    logic rst_n;
    logic busy;

    booth_seq_ctrl_if #(.N(N)) bus_if ();

    booth_seq_ctrl #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [2*N-1:0] exp_q[$];
    int pass_cnt = 0;
    int fail_cnt = 0;
    int total_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [2*N-1:0] model(input logic [N-1:0] m, input logic [N-1:0] q);
        logic signed [2*N-1:0] p;
        p = $signed(m) * $signed(q);
        return p;
    endfunction

    // Present an operand pair for one accepting edge; expected product queued.
    task automatic send(input string tag, input logic [N-1:0] m, input logic [N-1:0] q,
                        input logic [2*N-1:0] exp);
        @(negedge clk);
        bus_if.in_m     = m;
        bus_if.in_q     = q;
        bus_if.in_valid = 1'b1;
        check({tag, "_in_ready"}, 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(exp);
        #1 bus_if.in_valid = 1'b0;
    endtask

    // Wait (bounded) for out_valid, check latency and product; stays at that negedge.
    task automatic wait_valid(input string tag, input int exp_lat);
        int lat;
        bit seen;
        logic [2*N-1:0] e;
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 40 && !seen; i++) begin
            @(negedge clk);
            if (bus_if.out_valid === 1'b1) begin
                seen = 1'b1;
                lat  = i;
            end
        end
        check({tag, "_seen"}, 32'(seen), 32'd1);
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        if (exp_q.size() == 0) begin
            check({tag, "_queue"}, 32'(exp_q.size()), 32'd1);
        end else begin
            e = exp_q.pop_front();
            check({tag, "_out_p"}, 32'(bus_if.out_p), 32'(e));
        end
    endtask

    // Pulse out_ready for one edge and confirm the return to IDLE.
    task automatic consume(input string tag);
        bus_if.out_ready = 1'b1;
        @(posedge clk);
        #1 bus_if.out_ready = 1'b0;
        @(negedge clk);
        check({tag, "_ov_low"}, 32'(bus_if.out_valid), 32'd0);
        check({tag, "_ir_high"}, 32'(bus_if.in_ready), 32'd1);
        check({tag, "_busy_low"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [2*N-1:0] held;
        logic [N-1:0]   rm, rq;

        rst_n            = 1'b0;
        bus_if.in_valid  = 1'b0;
        bus_if.in_m      = '0;
        bus_if.in_q      = '0;
        bus_if.out_ready = 1'b0;

        // Reset state
        @(negedge clk);
        check("rst_in_ready", 32'(bus_if.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        check("rst_out_p", 32'(bus_if.out_p), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic: 3 * -4
        send("basic", 8'h03, 8'hFC, 16'hFFF4);
        wait_valid("basic", N + 1);
        consume("basic");

        // Extreme operands
        send("ext1", 8'h80, 8'h80, 16'h4000);
        wait_valid("ext1", N + 1);
        consume("ext1");
        send("ext2", 8'h7F, 8'h80, 16'hC080);
        wait_valid("ext2", N + 1);
        consume("ext2");
        send("ext3", 8'h80, 8'h7F, 16'hC080);
        wait_valid("ext3", N + 1);
        consume("ext3");

        // Backpressure: 5 * 7 held for 6 cycles, a second pair is refused
        send("bp", 8'h05, 8'h07, 16'h0023);
        wait_valid("bp", N + 1);
        held = bus_if.out_p;
        bus_if.in_m     = 8'h09;
        bus_if.in_q     = 8'h09;
        bus_if.in_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("bp_ov_hold", 32'(bus_if.out_valid), 32'd1);
            check("bp_out_p_hold", 32'(bus_if.out_p), 32'h0023);
            check("bp_in_ready_low", 32'(bus_if.in_ready), 32'd0);
        end
        bus_if.in_valid = 1'b0;
        check("bp_out_p_same", 32'(bus_if.out_p), 32'(held));
        consume("bp");
        repeat (2) @(negedge clk);
        check("bp_no_extra", 32'(bus_if.out_valid | busy), 32'd0);

        // Simultaneous out_ready and in_valid in DONE
        send("sim1", 8'h06, 8'hFD, 16'hFFEE);
        wait_valid("sim1", N + 1);
        bus_if.out_ready = 1'b1;
        bus_if.in_m      = 8'h02;
        bus_if.in_q      = 8'h02;
        bus_if.in_valid  = 1'b1;
        @(posedge clk);
        #1 bus_if.out_ready = 1'b0;
        @(negedge clk);
        check("sim_ov_low", 32'(bus_if.out_valid), 32'd0);
        check("sim_not_taken", 32'(bus_if.in_ready), 32'd1);
        @(posedge clk);
        exp_q.push_back(16'h0004);
        #1 bus_if.in_valid = 1'b0;
        wait_valid("sim2", N + 1);
        consume("sim2");

        // Reset in the middle of CALC
        send("rst_op", 8'h32, 8'hFD, 16'hFF6A);
        repeat (4) @(negedge clk);
        check("calc_busy", 32'(busy), 32'd1);
        check("calc_in_ready", 32'(bus_if.in_ready), 32'd0);
        rst_n = 1'b0;
        #1;
        check("abort_ov", 32'(bus_if.out_valid), 32'd0);
        check("abort_ir", 32'(bus_if.in_ready), 32'd1);
        check("abort_busy", 32'(busy), 32'd0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (N + 2) @(negedge clk);
        check("abort_no_result", 32'(bus_if.out_valid), 32'd0);
        send("post_rst", 8'hFF, 8'hFF, 16'h0001);
        wait_valid("post_rst", N + 1);
        consume("post_rst");

        // Zero operand
        send("zero", 8'h00, 8'hB3, 16'h0000);
        wait_valid("zero", ZERO_LAT);
        consume("zero");

        // A few random pairs against the reference model
        for (int k = 0; k < 4; k++) begin
            rm = 8'($urandom_range(255, 0));
            rq = 8'($urandom_range(255, 0));
            send("rand", rm, rq, model(rm, rq));
            wait_valid("rand", ((rm == 8'h00) || (rq == 8'h00)) ? ZERO_LAT : N + 1);
            consume("rand");
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
